// File: rtl/ysyx_23060061_pc_gen_if.sv
// Fetch/execute handshake bundle for the PC generator.
// The master side is the PC generator; the slave side is the IFU/EXU environment.
interface ysyx_23060061_pc_gen_if;
    logic [31:0] pc_o;
    logic        pc_valid;
    logic        pc_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_target;
    logic        BrEq;
    logic        BrLt;
    logic        BrUn;
    logic        ctl_err;

    modport master (
        output pc_o, pc_valid, ex_ready, BrUn, ctl_err,
        input  pc_ready, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               ex_target, BrEq, BrLt
    );

    modport slave (
        input  pc_o, pc_valid, ex_ready, BrUn, ctl_err,
        output pc_ready, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               ex_target, BrEq, BrLt
    );
endinterface

// File: rtl/ysyx_23060061_pc_gen.sv
// PC generator: issues fetch addresses, then resolves branch/jump outcomes into the next PC.
// Define YSYX_23060061_PC_GEN_BRCNT_EN to add saturating branch total/taken counters.
module ysyx_23060061_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_23060061_pc_gen_if.master       bus
`ifdef YSYX_23060061_PC_GEN_BRCNT_EN
    ,
    output logic [31:0]                  br_total,
    output logic [31:0]                  br_taken
`endif
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic        err_q;

    logic        ex_fire;
    logic        taken;
    logic        illegal;
    logic        redirect;
    logic        misaligned;
    logic [31:0] target_sel;
    logic [31:0] next_pc;

    assign bus.pc_o     = pc_q;
    assign bus.pc_valid = (state == ISSUE);
    assign bus.ex_ready = (state == WAIT);
    assign bus.BrUn     = bus.ex_funct3[1];
    assign bus.ctl_err  = err_q;

    assign ex_fire = (state == WAIT) && bus.ex_valid;

    always_comb begin
        taken = 1'b0;
        case (bus.ex_funct3)
            3'b000:         taken = bus.BrEq;
            3'b001:         taken = !bus.BrEq;
            3'b100, 3'b110: taken = bus.BrLt;
            3'b101, 3'b111: taken = !bus.BrLt;
            default:        taken = 1'b0;
        endcase
    end

    // A jump overrides any branch decode, so an odd funct3 on a jump is not an error.
    assign illegal    = bus.ex_is_branch && !bus.ex_is_jump &&
                        ((bus.ex_funct3 == 3'b010) || (bus.ex_funct3 == 3'b011));
    assign redirect   = bus.ex_is_jump || (bus.ex_is_branch && taken);
    assign target_sel = bus.ex_is_jump ? {bus.ex_target[31:1], 1'b0} : bus.ex_target;
    assign misaligned = redirect && target_sel[1];
    assign next_pc    = redirect ? target_sel : (pc_q + 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                BOOT: state <= ISSUE;
                ISSUE: begin
                    if (bus.pc_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ex_valid) begin
                        if (illegal || misaligned) begin
                            err_q <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc_q  <= next_pc;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

`ifdef YSYX_23060061_PC_GEN_BRCNT_EN
    logic branch_outcome;

    assign branch_outcome = ex_fire && bus.ex_is_branch && !bus.ex_is_jump && !illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_total <= 32'd0;
            br_taken <= 32'd0;
        end else if (branch_outcome) begin
            if (br_total != 32'hFFFF_FFFF) begin
                br_total <= br_total + 32'd1;
            end
            if (taken && (br_taken != 32'hFFFF_FFFF)) begin
                br_taken <= br_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ysyx_23060061_pc_gen.md
YSYX_23060061_PC_GEN -- requirements
Module: ysyx_23060061_pc_gen

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: pc_o  out  32  fetch address presented to IFU.
REQ-005 SHALL have port: pc_valid  out  1  pc_o valid for IFU.
REQ-006 SHALL have port: pc_ready  in  1  IFU accepts pc_o.
REQ-007 SHALL have port: ex_valid  in  1  EXU presents the resolved outcome of the last fetched instruction.
REQ-008 SHALL have port: ex_ready  out  1  pc_gen accepts the EXU outcome.
REQ-009 SHALL have port: ex_is_branch  in  1  instruction is a conditional branch.
REQ-010 SHALL have port: ex_is_jump  in  1  instruction is JAL/JALR.
REQ-011 SHALL have port: ex_funct3  in  3  branch funct3.
REQ-012 SHALL have port: ex_target  in  32  EXU-computed branch/jump target.
REQ-013 SHALL have port: BrEq  in  1  equality flag from branch comparator.
REQ-014 SHALL have port: BrLt  in  1  less-than flag from branch comparator.
REQ-015 SHALL have port: BrUn  out  1  unsigned-compare select to branch comparator.
REQ-016 SHALL have port: ctl_err  out  1  one-cycle pulse on illegal funct3 or misaligned taken target.

Function
REQ-017 SHALL implement FSM states BOOT, ISSUE, WAIT, HALT.
REQ-018 SHALL transition BOOT->ISSUE unconditionally on the first clock edge after reset release.
REQ-019 SHALL drive pc_valid=1 only in ISSUE and ex_ready=1 only in WAIT; both 0 in BOOT and HALT.
REQ-020 SHALL, in ISSUE, hold pc_o stable until pc_valid&&pc_ready, then transition to WAIT with pc_o unchanged.
REQ-021 SHALL, in WAIT, on ex_valid (handshake complete, since ex_ready=1), load the next PC and return to ISSUE; pc_valid SHALL reassert on the following cycle.
REQ-022 SHALL compute BrUn = ex_funct3[1] combinationally in every state.
REQ-023 SHALL decide taken per funct3: 000 BrEq, 001 !BrEq, 100/110 BrLt, 101/111 !BrLt.
REQ-024 SHALL treat ex_funct3 010/011 with ex_is_branch=1 as illegal: pulse ctl_err, enter HALT.
REQ-025 SHALL select next PC: jump -> {ex_target[31:1],1'b0}; taken branch -> ex_target; otherwise pc_o+4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-026 SHALL, when the selected target of a jump or taken branch has bit[1]=1, pulse ctl_err and enter HALT without updating pc_o.
REQ-027 SHALL give ex_is_jump priority when ex_is_jump and ex_is_branch are both 1.
REQ-028 SHALL ignore ex_valid outside WAIT and pc_ready outside ISSUE.
REQ-029 SHALL remain in HALT until rst.

Reset
REQ-030 SHALL on rst set pc_o=RESET_PC, state=BOOT, ctl_err=0, and counters (if present) to 0, asynchronously.
REQ-031 SHALL, on rst mid-handshake in any state, discard the pending transaction; the first post-reset pc_o SHALL be RESET_PC.

Configuration
REQ-032 SHALL, with YSYX_23060061_PC_GEN_BRCNT_EN defined, add outputs br_total[31:0] and br_taken[31:0], incremented on each accepted ex_is_branch outcome (br_taken only when taken), saturating at 32'hFFFF_FFFF.
REQ-033 SHALL, without YSYX_23060061_PC_GEN_BRCNT_EN, omit those ports and counter logic entirely, leaving behaviour otherwise identical.

Verification
REQ-034 SHALL cover: reset release, pc_ready=1 -> pc_valid rises the cycle after BOOT, pc_o=32'h8000_0000.
REQ-035 SHALL cover: pc_ready=0 for 5 cycles in ISSUE -> pc_o and pc_valid held; ex_valid pulses ignored.
REQ-036 SHALL cover: funct3=001, BrEq=0, target=32'h8000_0100 -> pc_o=32'h8000_0100; BrEq=1 -> pc_o=pc+4.
REQ-037 SHALL cover: funct3=110, BrLt=1 -> BrUn=1, taken; JALR target 32'h8000_0011 -> pc_o=32'h8000_0010.
REQ-038 SHALL cover: taken target 32'h8000_0102 or funct3=010 -> ctl_err one cycle, HALT, pc_valid=0 until rst.
REQ-039 SHALL cover (macro on): 3 branches, 2 taken -> br_total=3, br_taken=2; rst mid-WAIT -> both 0.
